// File: rtl/mem_request_ctrl.sv
// Memory-stage request sequencer: turns the MEM-stage dREN/dWEN into one dcache transaction.
// Latency: request seen in cycle N, strobes in N+1.., clearMemReq one cycle after dhit, stall low the cycle after that.
// Backpressure: stall is raised combinationally on a new request and held until the DONE cycle completes.
module mem_request_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              halt_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_in,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              stall,
  output logic              clearMemReq,
  output logic [DATA_W-1:0] memData,
  output logic              timeout_err,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              req;
  logic              dmemREN_nxt, dmemWEN_nxt, clear_nxt, timeout_nxt;
  logic [DATA_W-1:0] dmemaddr_nxt, dmemstore_nxt, mem_data_nxt;
  logic [31:0]       stall_cycles_nxt;

  // a halted instruction never reaches the cache
  assign req = (dREN_in | dWEN_in) & ~halt_in;

  // state and all registered outputs; reset abandons any transaction in flight
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      dmemREN      <= 1'b0;
      dmemWEN      <= 1'b0;
      dmemaddr     <= '0;
      dmemstore    <= '0;
      clearMemReq  <= 1'b0;
      memData      <= '0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      dmemREN      <= dmemREN_nxt;
      dmemWEN      <= dmemWEN_nxt;
      dmemaddr     <= dmemaddr_nxt;
      dmemstore    <= dmemstore_nxt;
      clearMemReq  <= clear_nxt;
      memData      <= mem_data_nxt;
      timeout_err  <= timeout_nxt;
      stall_cycles <= stall_cycles_nxt;
    end
  end

  // next-state, next register values and the combinational stall
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    dmemREN_nxt   = dmemREN;
    dmemWEN_nxt   = dmemWEN;
    dmemaddr_nxt  = dmemaddr;
    dmemstore_nxt = dmemstore;
    clear_nxt     = 1'b0;
    mem_data_nxt  = memData;
    timeout_nxt   = timeout_err;
    stall         = 1'b0;

    case (state)
      IDLE: begin
        // freeze the pipe in the same cycle the request appears
        stall = req;
        if (req) begin
          dmemaddr_nxt  = addr_in;
          dmemstore_nxt = store_in;
          // a simultaneous read and write issues only the write
          dmemWEN_nxt   = dWEN_in;
          dmemREN_nxt   = dREN_in & ~dWEN_in;
          wait_cnt_nxt  = '0;
          state_nxt     = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dhit) begin
          dmemREN_nxt  = 1'b0;
          dmemWEN_nxt  = 1'b0;
          mem_data_nxt = dmemREN ? dmemload : '0;
          clear_nxt    = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = DONE;
        end else begin
          if (wait_cnt != CNT_MAX) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
          // flag is informational only; the request keeps waiting for dhit
          if (wait_cnt_nxt >= TIMEOUT_C) begin
            timeout_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        // clearMemReq is high this cycle; the register drops its request at the edge
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    stall_cycles_nxt = stall_cycles;
    if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles_nxt = stall_cycles + 32'd1;
    end
  end

endmodule
